// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg: constants shared by the RV32I memory-access stage.
//   - funct3 load/store size codes (B, H, W, BU, HU)
//   - state encoding for the MA bus-access FSM (IDLE, REQ, DONE)
package rv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    MA_IDLE = 2'd0,
    MA_REQ  = 2'd1,
    MA_DONE = 2'd2
  } ma_state_e;

endpackage

// File: rtl/ld_align.sv
// ld_align: combinational load-data alignment for RV32I loads.
// Ports:
//   word   in  32 : raw word read from data memory
//   adr    in   2 : low effective-address bits (byte lane select)
//   code   in   3 : funct3 load code (B/H/W/BU/HU)
//   result out 32 : selected byte/halfword, sign- or zero-extended
module ld_align
  import rv_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  adr,
  input  logic [2:0]  code,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (adr)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    // Halfword lane picked by adr[1] only; adr[0] is ignored for halves.
    half_sel = adr[1] ? word[31:16] : word[15:0];

    case (code)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   result = {24'h0, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_HU:   result = {16'h0, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/ma_stage.sv
// ma_stage: RV32I memory-access pipeline stage.
// Drives a single-outstanding req/ack data bus, requests a pipeline hold
// while an access is in flight, aligns load data and registers the
// write-back bundle plus two forwarding taps.
// Ports:
//   clk, rst_n                    : clock, async active-low reset
//   cmd_ld_ma/cmd_st_ma           : load/store present in MA
//   rd_adr_ma, rd_data_ma         : dest register, ALU result / eff. address
//   st_data_ma, ldst_code_ma      : store data, funct3 size code
//   wbk_rd_reg_ma                 : register write enable
//   stall                         : global stall (includes ma_stall_req)
//   ma_stall_req                  : combinational hold request
//   dmem_req/we/adr/be/wdata      : registered bus request fields
//   dmem_ack, dmem_rdata          : completion strobe, read data
//   rd_adr_wb, wbk_rd_reg_wb      : registered write-back bundle
//   wbk_data_wb, wbk_data_wb2     : write-back data and its one-step delay
//   ma_misalign                   : misalign pulse (MA_MISALIGN_TRAP_EN only)
// Configuration macro: MA_MISALIGN_TRAP_EN enables misaligned-access trapping.
module ma_stage
  import rv_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_ld_ma,
  input  logic        cmd_st_ma,
  input  logic [4:0]  rd_adr_ma,
  input  logic [31:0] rd_data_ma,
  input  logic [31:0] st_data_ma,
  input  logic [2:0]  ldst_code_ma,
  input  logic        wbk_rd_reg_ma,
  input  logic        stall,
  output logic        ma_stall_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [29:0] dmem_adr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [4:0]  rd_adr_wb,
  output logic        wbk_rd_reg_wb,
  output logic [31:0] wbk_data_wb,
  output logic [31:0] wbk_data_wb2
`ifdef MA_MISALIGN_TRAP_EN
  ,
  output logic        ma_misalign
`endif
);

  ma_state_e   state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [29:0] adr_q, adr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] ld_buf_q, ld_buf_d;
  logic [4:0]  rd_adr_wb_q, rd_adr_wb_d;
  logic        wen_wb_q, wen_wb_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [31:0] wb_data2_q, wb_data2_d;

  logic        mem_op;
  logic        misalign;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [31:0] ld_aligned;

  ld_align u_ld_align (
    .word   (ld_buf_q),
    .adr    (rd_data_ma[1:0]),
    .code   (ldst_code_ma),
    .result (ld_aligned)
  );

  assign mem_op = cmd_ld_ma | cmd_st_ma;

`ifdef MA_MISALIGN_TRAP_EN
  always_comb begin
    misalign = 1'b0;
    if (mem_op && state_q == MA_IDLE) begin
      case (ldst_code_ma)
        F3_H, F3_HU: misalign = rd_data_ma[0];
        F3_W:        misalign = |rd_data_ma[1:0];
        default:     misalign = 1'b0;
      endcase
    end
  end
  assign ma_misalign = misalign;
`else
  assign misalign = 1'b0;
`endif

  // Held low in DONE so the pipeline advances exactly once per access.
  assign ma_stall_req = mem_op & (state_q != MA_DONE) & ~misalign;

  always_comb begin
    case (ldst_code_ma[1:0])
      2'b00: begin
        be_calc    = 4'b0001 << rd_data_ma[1:0];
        wdata_calc = {4{st_data_ma[7:0]}};
      end
      2'b01: begin
        be_calc    = 4'b0011 << {rd_data_ma[1], 1'b0};
        wdata_calc = {2{st_data_ma[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = st_data_ma;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    we_d     = we_q;
    adr_d    = adr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    ld_buf_d = ld_buf_q;
    case (state_q)
      MA_IDLE: begin
        if (mem_op && !misalign) begin
          state_d = MA_REQ;
          req_d   = 1'b1;
          we_d    = cmd_st_ma;
          adr_d   = rd_data_ma[31:2];
          be_d    = be_calc;
          wdata_d = wdata_calc;
        end
      end
      MA_REQ: begin
        if (dmem_ack) begin
          state_d = MA_DONE;
          req_d   = 1'b0;
          if (cmd_ld_ma) ld_buf_d = dmem_rdata;
        end
      end
      MA_DONE: begin
        if (!stall) state_d = MA_IDLE;
      end
      default: state_d = MA_IDLE;
    endcase
  end

  always_comb begin
    rd_adr_wb_d = rd_adr_wb_q;
    wen_wb_d    = wen_wb_q;
    wb_data_d   = wb_data_q;
    wb_data2_d  = wb_data2_q;
    if (!stall) begin
      rd_adr_wb_d = rd_adr_ma;
      wen_wb_d    = wbk_rd_reg_ma & ~misalign;
      wb_data_d   = cmd_ld_ma ? ld_aligned : rd_data_ma;
      wb_data2_d  = wb_data_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= MA_IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      ld_buf_q    <= '0;
      rd_adr_wb_q <= '0;
      wen_wb_q    <= 1'b0;
      wb_data_q   <= '0;
      wb_data2_q  <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      ld_buf_q    <= ld_buf_d;
      rd_adr_wb_q <= rd_adr_wb_d;
      wen_wb_q    <= wen_wb_d;
      wb_data_q   <= wb_data_d;
      wb_data2_q  <= wb_data2_d;
    end
  end

  assign dmem_req      = req_q;
  assign dmem_we       = we_q;
  assign dmem_adr      = adr_q;
  assign dmem_be       = be_q;
  assign dmem_wdata    = wdata_q;
  assign rd_adr_wb     = rd_adr_wb_q;
  assign wbk_rd_reg_wb = wen_wb_q;
  assign wbk_data_wb   = wb_data_q;
  assign wbk_data_wb2  = wb_data2_q;

endmodule

// File: tb/tb_ma_stage.sv
module tb_ma_stage;
  import rv_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_ld_ma, cmd_st_ma;
  logic [4:0]  rd_adr_ma;
  logic [31:0] rd_data_ma, st_data_ma;
  logic [2:0]  ldst_code_ma;
  logic        wbk_rd_reg_ma;
  logic        ext_stall;
  logic        stall;
  logic        ma_stall_req;
  logic        dmem_req, dmem_we;
  logic [29:0] dmem_adr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [4:0]  rd_adr_wb;
  logic        wbk_rd_reg_wb;
  logic [31:0] wbk_data_wb, wbk_data_wb2;
`ifdef MA_MISALIGN_TRAP_EN
  logic        ma_misalign;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign stall = ma_stall_req | ext_stall;

  ma_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_ld_ma     (cmd_ld_ma),
    .cmd_st_ma     (cmd_st_ma),
    .rd_adr_ma     (rd_adr_ma),
    .rd_data_ma    (rd_data_ma),
    .st_data_ma    (st_data_ma),
    .ldst_code_ma  (ldst_code_ma),
    .wbk_rd_reg_ma (wbk_rd_reg_ma),
    .stall         (stall),
    .ma_stall_req  (ma_stall_req),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_adr      (dmem_adr),
    .dmem_be       (dmem_be),
    .dmem_wdata    (dmem_wdata),
    .dmem_ack      (dmem_ack),
    .dmem_rdata    (dmem_rdata),
    .rd_adr_wb     (rd_adr_wb),
    .wbk_rd_reg_wb (wbk_rd_reg_wb),
    .wbk_data_wb   (wbk_data_wb),
    .wbk_data_wb2  (wbk_data_wb2)
`ifdef MA_MISALIGN_TRAP_EN
    ,
    .ma_misalign   (ma_misalign)
`endif
  );

  task automatic chk(input string tag, input logic ok, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (ok !== 1'b1) begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_access(input logic ld, input logic [31:0] adr, input logic [2:0] code,
                            input logic [31:0] sdata, input logic [31:0] rdata,
                            input int unsigned waits, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata, input logic [4:0] rd, input logic wen);
    logic [29:0] exp_adr;
    exp_adr       = adr[31:2];
    cmd_ld_ma     = ld;
    cmd_st_ma     = ~ld;
    rd_data_ma    = adr;
    ldst_code_ma  = code;
    st_data_ma    = sdata;
    rd_adr_ma     = rd;
    wbk_rd_reg_ma = wen;
    #1;
    chk("stall_req_c0", ma_stall_req === 1'b1, ma_stall_req, 1'b1);
    chk("req_c0", dmem_req === 1'b0, dmem_req, 1'b0);
    for (int unsigned i = 0; i <= waits; i++) begin
      next_cyc();
      chk("req_held", dmem_req === 1'b1, dmem_req, 1'b1);
      chk("stall_req_req", ma_stall_req === 1'b1, ma_stall_req, 1'b1);
      chk("be_held", dmem_be === exp_be, dmem_be, exp_be);
      chk("wdata_held", dmem_wdata === exp_wdata, dmem_wdata, exp_wdata);
      chk("adr_held", dmem_adr === exp_adr, dmem_adr, exp_adr);
      chk("we_held", dmem_we === ~ld, dmem_we, ~ld);
      if (i == waits) begin
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
      end
    end
    next_cyc();
    dmem_ack   = 1'b0;
    dmem_rdata = 32'h0;
    #1;
    chk("stall_req_done", ma_stall_req === 1'b0, ma_stall_req, 1'b0);
    chk("req_done", dmem_req === 1'b0, dmem_req, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; cmd_ld_ma = 1'b0; cmd_st_ma = 1'b0; rd_adr_ma = '0;
    rd_data_ma = '0; st_data_ma = '0; ldst_code_ma = '0; wbk_rd_reg_ma = 1'b0;
    ext_stall = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
    next_cyc();
    next_cyc();
    chk("rst_req", dmem_req === 1'b0, dmem_req, 1'b0);
    chk("rst_we", dmem_we === 1'b0, dmem_we, 1'b0);
    chk("rst_adr", dmem_adr === 30'h0, dmem_adr, 30'h0);
    chk("rst_be", dmem_be === 4'h0, dmem_be, 4'h0);
    chk("rst_wdata", dmem_wdata === 32'h0, dmem_wdata, 32'h0);
    chk("rst_rd_adr_wb", rd_adr_wb === 5'h0, rd_adr_wb, 5'h0);
    chk("rst_wen_wb", wbk_rd_reg_wb === 1'b0, wbk_rd_reg_wb, 1'b0);
    chk("rst_wb", wbk_data_wb === 32'h0, wbk_data_wb, 32'h0);
    chk("rst_wb2", wbk_data_wb2 === 32'h0, wbk_data_wb2, 32'h0);
    chk("rst_stall_req", ma_stall_req === 1'b0, ma_stall_req, 1'b0);
    rst_n = 1'b1;
    next_cyc();

    mem_access(1'b1, 32'h100, F3_W, 32'h0, 32'hDEADBEEF, 0, 4'b1111, 32'h0, 5'd5, 1'b1);
    chk("lw_wb_not_yet", wbk_data_wb === 32'h0, wbk_data_wb, 32'h0);
    next_cyc();
    chk("lw_wb", wbk_data_wb === 32'hDEADBEEF, wbk_data_wb, 32'hDEADBEEF);
    chk("lw_rd", rd_adr_wb === 5'd5, rd_adr_wb, 5'd5);
    chk("lw_wen", wbk_rd_reg_wb === 1'b1, wbk_rd_reg_wb, 1'b1);
    chk("lw_wb2", wbk_data_wb2 === 32'h0, wbk_data_wb2, 32'h0);

    cmd_ld_ma = 1'b0; cmd_st_ma = 1'b0; rd_data_ma = 32'h11111111; rd_adr_ma = 5'd7; wbk_rd_reg_ma = 1'b1;
    #1;
    chk("alu_stall_req", ma_stall_req === 1'b0, ma_stall_req, 1'b0);
    next_cyc();
    chk("alu_wb", wbk_data_wb === 32'h11111111, wbk_data_wb, 32'h11111111);
    chk("alu_wb2", wbk_data_wb2 === 32'hDEADBEEF, wbk_data_wb2, 32'hDEADBEEF);
    chk("alu_rd", rd_adr_wb === 5'd7, rd_adr_wb, 5'd7);

    mem_access(1'b1, 32'h103, F3_B, 32'h0, 32'h80FF7F01, 0, 4'b1000, 32'h0, 5'd3, 1'b1);
    next_cyc();
    chk("lb_wb", wbk_data_wb === 32'hFFFFFF80, wbk_data_wb, 32'hFFFFFF80);
    mem_access(1'b1, 32'h103, F3_BU, 32'h0, 32'h80FF7F01, 0, 4'b1000, 32'h0, 5'd3, 1'b1);
    next_cyc();
    chk("lbu_wb", wbk_data_wb === 32'h00000080, wbk_data_wb, 32'h00000080);
    mem_access(1'b1, 32'h102, F3_H, 32'h0, 32'h80FF7F01, 0, 4'b1100, 32'h0, 5'd3, 1'b1);
    next_cyc();
    chk("lh_wb", wbk_data_wb === 32'hFFFF80FF, wbk_data_wb, 32'hFFFF80FF);
    mem_access(1'b1, 32'h100, F3_HU, 32'h0, 32'h80FF7F01, 0, 4'b0011, 32'h0, 5'd3, 1'b1);
    next_cyc();
    chk("lhu_wb", wbk_data_wb === 32'h00007F01, wbk_data_wb, 32'h00007F01);

    mem_access(1'b0, 32'h202, F3_H, 32'h1234ABCD, 32'h0, 4, 4'b1100, 32'hABCDABCD, 5'd9, 1'b0);
    next_cyc();
    chk("sh_wen", wbk_rd_reg_wb === 1'b0, wbk_rd_reg_wb, 1'b0);
    chk("sh_wb", wbk_data_wb === 32'h00000202, wbk_data_wb, 32'h00000202);
    chk("sh_rd", rd_adr_wb === 5'd9, rd_adr_wb, 5'd9);
    mem_access(1'b0, 32'h201, F3_B, 32'h000000A5, 32'h0, 1, 4'b0010, 32'hA5A5A5A5, 5'd0, 1'b0);
    next_cyc();
    chk("sb_wb", wbk_data_wb === 32'h00000201, wbk_data_wb, 32'h00000201);

    mem_access(1'b1, 32'h104, F3_W, 32'h0, 32'hCAFEF00D, 0, 4'b1111, 32'h0, 5'd4, 1'b1);
    ext_stall = 1'b1;
    for (int unsigned k = 0; k < 3; k++) begin
      next_cyc();
      if (k == 2) ext_stall = 1'b0;
      chk("stl_req", dmem_req === 1'b0, dmem_req, 1'b0);
      chk("stl_stall_req", ma_stall_req === 1'b0, ma_stall_req, 1'b0);
      chk("stl_wb_hold", wbk_data_wb === 32'h00000201, wbk_data_wb, 32'h00000201);
      chk("stl_wb2_hold", wbk_data_wb2 === 32'h00000202, wbk_data_wb2, 32'h00000202);
    end
    next_cyc();
    chk("stl_wb", wbk_data_wb === 32'hCAFEF00D, wbk_data_wb, 32'hCAFEF00D);
    chk("stl_wb2", wbk_data_wb2 === 32'h00000201, wbk_data_wb2, 32'h00000201);

    cmd_ld_ma = 1'b1; cmd_st_ma = 1'b0; rd_data_ma = 32'h108; ldst_code_ma = F3_W; rd_adr_ma = 5'd6; wbk_rd_reg_ma = 1'b1;
    next_cyc();
    chk("mr_req", dmem_req === 1'b1, dmem_req, 1'b1);
    #1;
    rst_n = 1'b0;
    cmd_ld_ma = 1'b0; rd_data_ma = '0; rd_adr_ma = '0; wbk_rd_reg_ma = 1'b0;
    #1;
    chk("mr_req_drop", dmem_req === 1'b0, dmem_req, 1'b0);
    chk("mr_adr", dmem_adr === 30'h0, dmem_adr, 30'h0);
    chk("mr_be", dmem_be === 4'h0, dmem_be, 4'h0);
    chk("mr_wb", wbk_data_wb === 32'h0, wbk_data_wb, 32'h0);
    chk("mr_wb2", wbk_data_wb2 === 32'h0, wbk_data_wb2, 32'h0);
    chk("mr_rd", rd_adr_wb === 5'h0, rd_adr_wb, 5'h0);
    next_cyc();
    rst_n = 1'b1;
    next_cyc();
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    next_cyc();
    dmem_ack = 1'b0; dmem_rdata = '0;
    chk("late_ack_req", dmem_req === 1'b0, dmem_req, 1'b0);
    chk("late_ack_stall", ma_stall_req === 1'b0, ma_stall_req, 1'b0);
    chk("late_ack_wb", wbk_data_wb === 32'h0, wbk_data_wb, 32'h0);
    chk("late_ack_wen", wbk_rd_reg_wb === 1'b0, wbk_rd_reg_wb, 1'b0);
    next_cyc();
    chk("late_ack_req2", dmem_req === 1'b0, dmem_req, 1'b0);

`ifdef MA_MISALIGN_TRAP_EN
    cmd_ld_ma = 1'b1; rd_data_ma = 32'h101; ldst_code_ma = F3_W; rd_adr_ma = 5'd8; wbk_rd_reg_ma = 1'b1;
    #1;
    chk("mis_pulse", ma_misalign === 1'b1, ma_misalign, 1'b1);
    chk("mis_stall_req", ma_stall_req === 1'b0, ma_stall_req, 1'b0);
    next_cyc();
    cmd_ld_ma = 1'b0; rd_data_ma = '0; wbk_rd_reg_ma = 1'b0;
    #1;
    chk("mis_pulse_end", ma_misalign === 1'b0, ma_misalign, 1'b0);
    chk("mis_req", dmem_req === 1'b0, dmem_req, 1'b0);
    chk("mis_wen", wbk_rd_reg_wb === 1'b0, wbk_rd_reg_wb, 1'b0);
    chk("mis_rd", rd_adr_wb === 5'd8, rd_adr_wb, 5'd8);
    next_cyc();
    chk("mis_req2", dmem_req === 1'b0, dmem_req, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ma_stage.md
# ma_stage

Memory-access stage of the RV32I pipeline, sitting between the execution stage and write-back. It consumes the registered EX→MA command bundle (`cmd_ld_ma`, `cmd_st_ma`, `rd_adr_ma`, `rd_data_ma`, `st_data_ma`, `ldst_code_ma`, `wbk_rd_reg_ma`). It drives a single-outstanding request/acknowledge data-memory bus, holds the pipeline through a stall request while an access is in flight, and aligns and sign-extends load data. It also registers the write-back bundle and the forwarding values `wbk_data_wb` and `wbk_data_wb2`.

## Interface
- No parameters; widths fixed by RV32I.
- `clk` in 1: sole clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_ld_ma`, `cmd_st_ma` in 1 each: load or store present in MA; never both.
- `rd_adr_ma` in 5: destination register.
- `rd_data_ma` in 32: ALU result; this is the effective address for load/store.
- `st_data_ma` in 32: store data (rs2).
- `ldst_code_ma` in 3: funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `wbk_rd_reg_ma` in 1: register write enable.
- `stall` in 1: global pipeline stall, which is the OR of all sources including `ma_stall_req`.
- `ma_stall_req` out 1: combinational request to hold the pipeline.
- `dmem_req` out 1: registered bus request.
- `dmem_we` out 1: write enable.
- `dmem_adr` out 30: word address.
- `dmem_be` out 4: byte enables.
- `dmem_wdata` out 32: lane-replicated store data.
- `dmem_ack` in 1: one-cycle completion strobe.
- `dmem_rdata` in 32: read word, valid with `dmem_ack`.
- `rd_adr_wb` out 5: registered destination register.
- `wbk_rd_reg_wb` out 1: registered write enable.
- `wbk_data_wb` out 32: registered write-back data.
- `wbk_data_wb2` out 32: `wbk_data_wb` delayed by one un-stalled cycle.
- `ma_misalign` out 1: misalignment pulse; only present under the configuration macro.

## Operation
- FSM states and transitions:
  - IDLE → REQ when `cmd_ld_ma|cmd_st_ma` (and the access is not trapped as misaligned).
  - REQ → DONE on `dmem_ack`.
  - DONE → IDLE when `~stall`; DONE holds while `stall` is high from any other source.
- `ma_stall_req` = (`cmd_ld_ma|cmd_st_ma`) & state≠DONE. It is therefore low in DONE, which lets the pipeline advance exactly once per access; the access is never relaunched.
- In REQ: `dmem_req`=1, and `dmem_adr`, `dmem_we`, `dmem_be`, `dmem_wdata` are registered on entry and held stable until the ack.
- Byte enables:
  - byte access: `dmem_be` = 0001 << adr[1:0].
  - halfword access: `dmem_be` = 0011 << {adr[1],1'b0}.
  - word access: `dmem_be` = 1111.
- Store data replication: byte data ×4, halfword data ×2.
- On ack of a load, `dmem_rdata` is captured into a load buffer. Extraction uses adr[1:0]: sign-extend for B/H, zero-extend for BU/HU.
- Write-back registers update when `~stall`:
  - `wbk_data_wb` = load ? aligned load buffer : `rd_data_ma`.
  - `rd_adr_wb` and `wbk_rd_reg_wb` pass through.
  - `wbk_data_wb2` ← the previous `wbk_data_wb`.
- Stores write no register: `wbk_rd_reg_wb` follows `wbk_rd_reg_ma`, which EX already clears for stores.
- Reset values: state IDLE; every output 0.
- Reset mid-access: the FSM returns to IDLE and `dmem_req` drops immediately; a late `dmem_ack` arriving in IDLE is ignored.

## Timing
- `ma_stall_req` asserts in cycle 0, the cycle the command appears.
- `dmem_req` first rises in cycle 1.
- The earliest ack is in cycle 1, giving DONE in cycle 2 and the write-back registers loaded at the end of cycle 2. Minimum occupancy is 3 cycles.
- Each extra wait cycle on `dmem_ack` adds one cycle of occupancy.
- Non-memory instructions: single cycle, no stall request.
- Back-to-back accesses: the second access enters IDLE at cycle 3 and its `dmem_req` rises at cycle 4. There is no gap beyond that.

## Configuration
- `MA_MISALIGN_TRAP_EN` defined:
  - Misaligned cases are: H/HU/SH with adr[0]=1, and W/SW with adr[1:0]≠0.
  - For these, no bus request is issued. `ma_misalign` pulses for one cycle in cycle 0, `ma_stall_req` stays low, and `wbk_rd_reg_wb` is forced to 0.
- Macro undefined:
  - No `ma_misalign` port.
  - Low address bits below access size are ignored: halfword uses adr[1] only, word uses adr[31:2].

## Structure
- Shared package `rv_mem_pkg`: funct3 load/store code constants and the FSM state encoding (IDLE, REQ, DONE).
- One sub-module, `ld_align`: purely combinational byte/halfword extraction plus sign/zero extension, taking (word, adr[1:0], code) → 32-bit result.

## Test plan
- LW at 0x100, `dmem_rdata`=0xDEADBEEF, ack in the first REQ cycle → `ma_stall_req` high for cycles 0–1; `wbk_data_wb`=0xDEADBEEF; total occupancy 3 cycles.
- LB at 0x103 and LBU at 0x103, rdata=0x80FF7F01 → `wbk_data_wb` = 0xFFFFFF80 and 0x00000080 respectively.
- SH at 0x202, `st_data_ma`=0x1234ABCD, ack delayed 4 cycles → `dmem_be`=1100, `dmem_wdata`=0xABCDABCD, both held stable across all wait cycles; `wbk_rd_reg_wb`=0.
- External `stall` held 3 cycles while in DONE → state remains DONE, no second `dmem_req`; the write-back update occurs in the first cycle `stall` is low.
- `rst_n` asserted while in REQ, then ack arrives after release → `dmem_req` falls asynchronously, the ack is ignored, and all outputs read 0.
- With `MA_MISALIGN_TRAP_EN`: LW at 0x101 → `ma_misalign` is a one-cycle pulse, `dmem_req` never rises, `wbk_rd_reg_wb`=0.
